pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 28 ++
 rtl/pc_sequencer_cond_eval.sv | 36 +++
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: branch kinds, ARM condition codes, FSM states.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    BK_NONE  = 3'd0,
    BK_B     = 3'd1,
    BK_BCOND = 3'd2,
    BK_BR    = 3'd3,
    BK_CBZ   = 3'd4,
    BK_CBNZ  = 3'd5,
    BK_RSV6  = 3'd6,
    BK_BL    = 3'd7
  } br_kind_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_HS = 4'd2,  CC_LO = 4'd3,
    CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
    CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
    CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_cond_eval.sv
// ARM condition-code evaluator: flags are packed {V,C,N,Z}.
module cond_eval
  import pc_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic v, c, n, z;
  assign {v, c, n, z} = flags;

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      CC_EQ: taken = z;
      CC_NE: taken = !z;
      CC_HS: taken = c;
      CC_LO: taken = !c;
      CC_MI: taken = n;
      CC_PL: taken = !n;
      CC_VS: taken = v;
      CC_VC: taken = !v;
      CC_HI: taken = c && !z;
      CC_LS: taken = !c || z;
      CC_GE: taken = (n == v);
      CC_LT: taken = (n != v);
      CC_GT: taken = !z && (n == v);
      CC_LE: taken = z || (n != v);
      CC_AL: taken = 1'b1;
      CC_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer (IDLE/RUN/HALT) with relative, conditional, register and
// compare-zero branches. Define PC_SEQUENCER_LINK_EN to add BL (kind 7) and link outputs.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned OFF_W  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        br_kind,
  input  logic [3:0]        cond,
  input  logic [3:0]        flags,
  input  logic [OFF_W-1:0]  br_offset,
  input  logic [31:0]       reg_data,
  input  logic              instr_zero,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush,
`ifdef PC_SEQUENCER_LINK_EN
  output logic              halted,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr
`else
  output logic              halted
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;

  br_kind_e          kind;
  logic              cond_taken;
  logic              redirect;
  logic              halt_req;
  logic [ADDR_W-1:0] off_a, pc_inc, target;

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .taken (cond_taken)
  );

  // Sized cast of a signed value sign-extends or truncates to the PC width.
  assign off_a  = ADDR_W'($signed(br_offset));
  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    kind = br_kind_e'(br_kind);
`ifndef PC_SEQUENCER_LINK_EN
    if (kind == BK_BL) kind = BK_NONE;
`endif
    if (kind == BK_RSV6) kind = BK_NONE;

    redirect = 1'b0;
    target   = pc_q + off_a;
    case (kind)
      BK_B, BK_BL: redirect = 1'b1;
      BK_BCOND:    redirect = cond_taken;
      BK_BR: begin
        redirect = 1'b1;
        target   = reg_data[ADDR_W-1:0];
      end
      BK_CBZ:      redirect = (reg_data == '0);
      BK_CBNZ:     redirect = (reg_data != '0);
      default:     redirect = 1'b0;
    endcase

    halt_req = instr_zero || ((pc_q == '1) && (kind == BK_NONE));
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          // Halt wins over any branch presented on the same edge.
          if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = redirect ? target : pc_inc;
            flush_d = redirect;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  assign pc       = pc_q;
  assign flush    = flush_q;
  assign pc_valid = (state_q == ST_RUN);
  assign halted   = (state_q == ST_HALT);

`ifdef PC_SEQUENCER_LINK_EN
  assign link_we   = (state_q == ST_RUN) && !stall && !halt_req && (kind == BK_BL);
  assign link_addr = pc_inc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; link checks compile in with PC_SEQUENCER_LINK_EN.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  br_kind;
  logic [3:0]  cond;
  logic [3:0]  flags;
  logic [25:0] br_offset;
  logic [31:0] reg_data;
  logic        instr_zero;
  logic [6:0]  pc;
  logic        pc_valid;
  logic        flush;
  logic        halted;
`ifdef PC_SEQUENCER_LINK_EN
  logic        link_we;
  logic [6:0]  link_addr;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(7), .OFF_W(26)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_kind    (br_kind),
    .cond       (cond),
    .flags      (flags),
    .br_offset  (br_offset),
    .reg_data   (reg_data),
    .instr_zero (instr_zero),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .flush      (flush),
`ifdef PC_SEQUENCER_LINK_EN
    .halted     (halted),
    .link_we    (link_we),
    .link_addr  (link_addr)
`else
    .halted     (halted)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] k, input int off, input logic [31:0] rd);
    br_kind   = k;
    br_offset = 26'(off);
    reg_data  = rd;
  endtask

  task automatic goto(input logic [6:0] target);
    drive(3'd3, 0, {25'd0, target});
    step();
  endtask

  task automatic test_reset;
    rst = 1'b0; stall = 1'b1; cond = '0; flags = '0; instr_zero = 1'b0;
    drive(3'd1, 9, 32'd0);
    #3;
    tests++;
    if ({pc, pc_valid, flush, halted} !== {7'd0, 3'b000}) begin
      fails++;
      $display("FAIL reset_state pc=%0d valid=%b flush=%b halted=%b exp pc=0 valid=0 flush=0 halted=0",
               pc, pc_valid, flush, halted);
    end
    stall = 1'b0;
    drive(3'd0, 0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_run_seq;
    logic [6:0] exp_pc [4] = '{7'd0, 7'd1, 7'd2, 7'd3};
    #1;
    tests++;
    if ({pc, pc_valid} !== {7'd0, 1'b0}) begin
      fails++;
      $display("FAIL idle_state pc=%0d valid=%b exp pc=0 valid=0", pc, pc_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if ({pc, pc_valid, halted} !== {exp_pc[i], 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL run_seq[%0d] pc=%0d valid=%b halted=%b exp pc=%0d valid=1 halted=0",
                 i, pc, pc_valid, halted, exp_pc[i]);
      end
    end
  endtask

  task automatic test_bcond;
    // cond, flags {V,C,N,Z}, expected taken
    logic [3:0] cc  [10] = '{CC_EQ, CC_NE, CC_HS, CC_LT, CC_GE, CC_HI, CC_LS, CC_LE, CC_NV, CC_VS};
    logic [3:0] fl  [10] = '{4'b0001, 4'b0001, 4'b0100, 4'b0010, 4'b0010,
                             4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b1000};
    logic       tk  [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [6:0] e;
    goto(7'd10);
    cond = CC_GT; flags = 4'b0000; drive(3'd2, -3, 32'd0);
    step();
    tests++;
    if ({pc, flush} !== {7'd7, 1'b1}) begin
      fails++;
      $display("FAIL bcond_gt_taken pc=%0d flush=%b exp pc=7 flush=1", pc, flush);
    end
    drive(3'd0, 0, 32'd0);
    step();
    tests++;
    if ({pc, flush} !== {7'd8, 1'b0}) begin
      fails++;
      $display("FAIL bcond_after pc=%0d flush=%b exp pc=8 flush=0", pc, flush);
    end
    goto(7'd10);
    flags = 4'b0001; drive(3'd2, -3, 32'd0);
    step();
    tests++;
    if ({pc, flush} !== {7'd11, 1'b0}) begin
      fails++;
      $display("FAIL bcond_gt_not pc=%0d flush=%b exp pc=11 flush=0", pc, flush);
    end
    for (int i = 0; i < 10; i++) begin
      goto(7'd10);
      cond = cc[i]; flags = fl[i]; drive(3'd2, 5, 32'd0);
      step();
      e = tk[i] ? 7'd15 : 7'd11;
      tests++;
      if ({pc, flush} !== {e, tk[i]}) begin
        fails++;
        $display("FAIL cond_tab[%0d] pc=%0d flush=%b exp pc=%0d flush=%b", i, pc, flush, e, tk[i]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [2:0]  k  [6] = '{3'd1, 3'd3, 3'd1, 3'd4, 3'd5, 3'd6};
    int          of [6] = '{10, 0, 1, 5, 5, 5};
    logic [31:0] rd [6] = '{32'd0, 32'h1FF, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [6:0]  ep [6] = '{7'd2, 7'h7F, 7'd0, 7'd5, 7'd6, 7'd7};
    logic        ef [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    goto(7'd120);
    for (int i = 0; i < 6; i++) begin
      drive(k[i], of[i], rd[i]);
      step();
      tests++;
      if ({pc, flush, halted} !== {ep[i], ef[i], 1'b0}) begin
        fails++;
        $display("FAIL wrap_kinds[%0d] pc=%0d flush=%b halted=%b exp pc=%0d flush=%b halted=0",
                 i, pc, flush, halted, ep[i], ef[i]);
      end
    end
    drive(3'd5, -7, 32'd3);
    step();
    tests++;
    if ({pc, flush} !== {7'd0, 1'b1}) begin
      fails++;
      $display("FAIL cbnz_taken pc=%0d flush=%b exp pc=0 flush=1", pc, flush);
    end
  endtask

  task automatic test_stall;
    goto(7'd30);
    drive(3'd1, 4, 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({pc, flush, pc_valid} !== {7'd30, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL stall_hold[%0d] pc=%0d flush=%b valid=%b exp pc=30 flush=0 valid=1",
                 i, pc, flush, pc_valid);
      end
    end
    stall = 1'b0;
    step();
    tests++;
    if ({pc, flush} !== {7'd34, 1'b1}) begin
      fails++;
      $display("FAIL stall_release pc=%0d flush=%b exp pc=34 flush=1", pc, flush);
    end
    drive(3'd0, 0, 32'd0);
    step();
    tests++;
    if ({pc, flush} !== {7'd35, 1'b0}) begin
      fails++;
      $display("FAIL stall_once pc=%0d flush=%b exp pc=35 flush=0", pc, flush);
    end
  endtask

  task automatic test_link;
    goto(7'd20);
    drive(3'd7, 8, 32'd0);
`ifdef PC_SEQUENCER_LINK_EN
    #1;
    tests++;
    if ({link_we, link_addr} !== {1'b1, 7'd21}) begin
      fails++;
      $display("FAIL bl_link we=%b addr=%0d exp we=1 addr=21", link_we, link_addr);
    end
    step();
    tests++;
    if ({pc, flush} !== {7'd28, 1'b1}) begin
      fails++;
      $display("FAIL bl_target pc=%0d flush=%b exp pc=28 flush=1", pc, flush);
    end
    drive(3'd0, 0, 32'd0);
    #1;
    tests++;
    if (link_we !== 1'b0) begin
      fails++;
      $display("FAIL bl_pulse we=%b exp 0", link_we);
    end
`else
    step();
    tests++;
    if ({pc, flush} !== {7'd21, 1'b0}) begin
      fails++;
      $display("FAIL kind7_none pc=%0d flush=%b exp pc=21 flush=0", pc, flush);
    end
    drive(3'd0, 0, 32'd0);
`endif
  endtask

  task automatic test_halt;
    goto(7'd5);
    instr_zero = 1'b1;
    drive(3'd1, 4, 32'd0);
    step();
    tests++;
    if ({pc, halted, pc_valid, flush} !== {7'd5, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL halt_enter pc=%0d halted=%b valid=%b flush=%b exp pc=5 halted=1 valid=0 flush=0",
               pc, halted, pc_valid, flush);
    end
    instr_zero = 1'b0;
    drive(3'd3, 0, 32'd50);
    step();
    tests++;
    if ({pc, halted} !== {7'd5, 1'b1}) begin
      fails++;
      $display("FAIL halt_ignore pc=%0d halted=%b exp pc=5 halted=1", pc, halted);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({pc, halted, pc_valid, flush} !== {7'd0, 3'b000}) begin
      fails++;
      $display("FAIL async_reset pc=%0d halted=%b valid=%b flush=%b exp pc=0 halted=0 valid=0 flush=0",
               pc, halted, pc_valid, flush);
    end
    #2 rst = 1'b1;
    step();
    tests++;
    if ({pc, pc_valid, flush} !== {7'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL idle_ignore pc=%0d valid=%b flush=%b exp pc=0 valid=1 flush=0", pc, pc_valid, flush);
    end
    goto(7'd127);
    drive(3'd0, 0, 32'd0);
    step();
    tests++;
    if ({pc, halted} !== {7'd127, 1'b1}) begin
      fails++;
      $display("FAIL halt_max pc=%0d halted=%b exp pc=127 halted=1", pc, halted);
    end
  endtask

  initial begin
    test_reset();
    test_run_seq();
    test_bcond();
    test_wrap();
    test_stall();
    test_link();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
